// File: rtl/pipe_queue.sv
// Elastic pipeline register: DEPTH-entry circular queue with valid/ready on both
// sides plus stage-style flush (squash) and hold (stall) controls.
module pipe_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Ready depends only on occupancy and stage controls, never on out_ready_i.
    assign in_ready_o  = (cnt != FULL) && !hold_i && !flush_i;
    assign out_valid_o = (cnt != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i && !hold_i && !flush_i;
    assign out_data_o  = out_valid_o ? mem[rp] : '0;
    assign count_o     = cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= (wp == LAST) ? '0 : wp + 1'b1;
            end
            if (pop) begin
                rp <= (rp == LAST) ? '0 : rp + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Payload storage carries no reset; empty slots are masked at the output.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wp] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_pipe_queue.sv
// Directed bench for pipe_queue: three instances (DEPTH 2, 3 and 1) driven with
// hand-computed vectors covering reset, wrap, full, hold and flush behaviour.
module tb_pipe_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // DEPTH=2, WIDTH=16
    logic        v2 = 0, r2, ov2, or2 = 0, f2 = 0, h2 = 0;
    logic [15:0] d2 = '0, od2;
    logic [1:0]  c2;
    // DEPTH=3, WIDTH=8
    logic        v3 = 0, r3, ov3, or3 = 0, f3 = 0, h3 = 0;
    logic [7:0]  d3 = '0, od3;
    logic [1:0]  c3;
    // DEPTH=1, WIDTH=64
    logic        v1 = 0, r1, ov1, or1 = 0, f1 = 0, h1 = 0;
    logic [63:0] d1 = '0, od1;
    logic [0:0]  c1;

    pipe_queue #(.WIDTH(16), .DEPTH(2)) u_q2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v2), .in_ready_o(r2), .in_data_i(d2),
        .out_valid_o(ov2), .out_ready_i(or2), .out_data_o(od2),
        .flush_i(f2), .hold_i(h2), .count_o(c2)
    );
    pipe_queue #(.WIDTH(8), .DEPTH(3)) u_q3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v3), .in_ready_o(r3), .in_data_i(d3),
        .out_valid_o(ov3), .out_ready_i(or3), .out_data_o(od3),
        .flush_i(f3), .hold_i(h3), .count_o(c3)
    );
    pipe_queue #(.WIDTH(64), .DEPTH(1)) u_q1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_ready_o(r1), .in_data_i(d1),
        .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1),
        .flush_i(f1), .hold_i(h1), .count_o(c1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DEPTH=3 fill/drain table, one row per cycle, checked before the edge.
    localparam int T_V  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    localparam int T_D  [11] = '{1, 2, 3, 4, 4, 4, 5, 5, 0, 0, 0};
    localparam int T_OR [11] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0};
    localparam int T_CNT[11] = '{0, 1, 2, 3, 3, 2, 3, 2, 2, 1, 0};
    localparam int T_RDY[11] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1};
    localparam int T_OD [11] = '{0, 1, 1, 1, 1, 2, 2, 3, 4, 5, 0};

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_ov2", 64'(ov2), 64'd0);
        check("rst_c2", 64'(c2), 64'd0);
        check("rst_od2", 64'(od2), 64'd0);
        check("rst_r2", 64'(r2), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset mid-stream
        v2 = 1; d2 = 16'hAAAA; tick();
        d2 = 16'hBBBB; tick();
        v2 = 0;
        check("mid_c2_full", 64'(c2), 64'd2);
        check("mid_r2_full", 64'(r2), 64'd0);
        check("mid_od2", 64'(od2), 64'hAAAA);
        #2 rst = 1'b1;
        #1;
        check("mid_ov2", 64'(ov2), 64'd0);
        check("mid_c2", 64'(c2), 64'd0);
        check("mid_od2_zero", 64'(od2), 64'd0);
        check("mid_r2", 64'(r2), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        // DEPTH=3 fill/drain with pointer wrap
        for (int i = 0; i < 11; i++) begin
            v3 = T_V[i][0]; d3 = 8'(T_D[i]); or3 = T_OR[i][0];
            #1;
            check($sformatf("wrap_cnt[%0d]", i), 64'(c3), 64'(T_CNT[i]));
            check($sformatf("wrap_rdy[%0d]", i), 64'(r3), 64'(T_RDY[i]));
            check($sformatf("wrap_od[%0d]", i), 64'(od3), 64'(T_OD[i]));
            check($sformatf("wrap_ov[%0d]", i), 64'(ov3), 64'(T_CNT[i] != 0));
            tick();
        end
        v3 = 0; or3 = 0;

        // full plus pop: no pass-through while full
        v2 = 1; d2 = 16'h0011; tick();
        d2 = 16'h0022; tick();
        d2 = 16'h0033; or2 = 1;
        #1 check("full_r2", 64'(r2), 64'd0);
        tick();
        check("full_c2_after_pop", 64'(c2), 64'd1);
        check("full_od2_after_pop", 64'(od2), 64'h0022);
        check("full_r2_reopen", 64'(r2), 64'd1);
        tick();
        check("full_c2_pushpop", 64'(c2), 64'd1);
        check("full_od2_pushpop", 64'(od2), 64'h0033);
        v2 = 0; or2 = 0;

        // hold for three cycles with both sides active
        h2 = 1; v2 = 1; d2 = 16'h0044; or2 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold_r2[%0d]", i), 64'(r2), 64'd0);
            check($sformatf("hold_c2[%0d]", i), 64'(c2), 64'd1);
            check($sformatf("hold_od2[%0d]", i), 64'(od2), 64'h0033);
            tick();
        end
        h2 = 0;
        tick();
        check("hold_rel_c2", 64'(c2), 64'd1);
        check("hold_rel_od2", 64'(od2), 64'h0044);

        // flush beats hold and push
        d2 = 16'h0055; or2 = 0; tick();
        check("pre_flush_c2", 64'(c2), 64'd2);
        f2 = 1; h2 = 1; d2 = 16'h0066;
        #1 check("flush_r2", 64'(r2), 64'd0);
        tick();
        f2 = 0; h2 = 0; v2 = 0;
        check("flush_c2", 64'(c2), 64'd0);
        check("flush_ov2", 64'(ov2), 64'd0);
        check("flush_od2", 64'(od2), 64'd0);
        v2 = 1; d2 = 16'h0077; tick();
        v2 = 0;
        check("post_flush_od2", 64'(od2), 64'h0077);
        check("post_flush_c2", 64'(c2), 64'd1);

        // DEPTH=1 IF/ID stage register
        check("q1_idle_r1", 64'(r1), 64'd1);
        v1 = 1; d1 = 64'h0000_0004_2002_0001; tick();
        v1 = 0;
        check("q1_od1", od1, 64'h0000_0004_2002_0001);
        check("q1_ov1", 64'(ov1), 64'd1);
        check("q1_c1", 64'(c1), 64'd1);
        check("q1_r1_full", 64'(r1), 64'd0);
        f1 = 1; tick();
        f1 = 0;
        check("q1_flush_od1", od1, 64'd0);
        check("q1_flush_ov1", 64'(ov1), 64'd0);
        check("q1_flush_c1", 64'(c1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_queue.md
# pipe_queue

Parametrised elastic pipeline register: the successor to the fixed 64-bit clear/hold stage register used between CPU pipeline stages (IF/ID and later). It holds up to DEPTH entries of WIDTH bits with a valid/ready handshake on both sides, plus the existing stage-control semantics: synchronous flush (branch/jump squash) and hold (load-use stall). Intended first use: IF/ID with DEPTH=2, so instruction fetch keeps running one slot ahead while decode is stalled.

## Interface
- WIDTH, 64, payload width in bits (e.g. {pc_4, inst})
- DEPTH, 2, number of entries; any integer >= 1
- CW, $clog2(DEPTH+1), width of occupancy count (derived; not to be overridden)
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- in_valid_i  input  1  upstream offers in_data_i
- in_ready_o  output  1  queue accepts a push this cycle
- in_data_i  input  WIDTH  payload from upstream stage
- out_valid_o  output  1  head entry present
- out_ready_i  input  1  downstream consumes head this cycle
- out_data_o  output  WIDTH  head payload; all zeros when empty (bubble = NOP)
- flush_i  input  1  discard all entries (equivalent to stage clear)
- hold_i  input  1  freeze queue: no push, no pop (equivalent to stage hold)
- count_o  output  CW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular buffer, write pointer wp, read pointer rp, occupancy cnt; pointers increment modulo DEPTH (explicit wrap at DEPTH-1 -> 0, DEPTH need not be a power of two).
- in_ready_o = (cnt != DEPTH) && !hold_i && !flush_i.
- out_valid_o = (cnt != 0). out_data_o = mem[rp] when cnt != 0, else 0.
- push = in_valid_i && in_ready_o. pop = out_valid_o && out_ready_i && !hold_i && !flush_i.
- push only: mem[wp] <= in_data_i, wp++, cnt++. pop only: rp++, cnt--. push and pop together: both pointers advance, cnt unchanged.
- Full: in_ready_o = 0 even if a pop happens in the same cycle (no full-throughput pass-through at cnt == DEPTH; deliberate, keeps in_ready_o free of out_ready_i).
- Empty: pop impossible; out_data_o = 0.
- flush_i (priority 1): next edge wp <= 0, rp <= 0, cnt <= 0; same-cycle push and pop suppressed; payload in mem need not be cleared.
- hold_i (priority 2): state unchanged; out_valid_o/out_data_o continue to present head.
- flush_i and hold_i together: flush wins.
- in_valid_i while in_ready_o = 0: data ignored; upstream must hold in_data_i stable until accepted.

## Timing
- Reset (async assert, any time incl. mid-transfer): wp = rp = 0, cnt = 0 immediately; outputs: out_valid_o = 0, out_data_o = 0, count_o = 0, in_ready_o = 1 (if hold_i = 0 and flush_i = 0). Release synchronous to clk_i by system.
- Latency: entry pushed at edge k is visible on out_data_o with out_valid_o = 1 after edge k (one cycle, empty queue).
- count_o updates on the same edge as the push/pop/flush causing it.
- in_ready_o and pop qualification are combinational from cnt, hold_i, flush_i only; no combinational path in_valid_i -> out_* or out_ready_i -> in_ready_o.
- Sustained throughput: one entry per cycle when 0 < cnt < DEPTH and both sides ready.

## Test plan
- Reset mid-stream: DEPTH=2, push A, B (cnt=2), assert rst_i between edges -> out_valid_o, count_o, out_data_o drop to 0 without clock edge; in_ready_o = 1.
- Fill/drain with wrap: DEPTH=3, push 0x1..0x5 with out_ready_i toggling -> output order 1,2,3,4,5; in_ready_o = 0 exactly when count_o = 3; pointers wrap without loss.
- Full plus pop: DEPTH=2 full, in_valid_i = 1, out_ready_i = 1 -> pop occurs, no push, count_o 2 -> 1; next cycle push accepted, count_o stays 1 with simultaneous pop.
- Hold: cnt=1, hold_i = 1 for 3 cycles with in_valid_i = out_ready_i = 1 -> in_ready_o = 0, count_o = 1, out_data_o stable; after release, pop and push resume next edge.
- Flush vs hold vs push: cnt=2, flush_i = hold_i = in_valid_i = 1 -> after edge count_o = 0, out_valid_o = 0, out_data_o = 0; input word not stored.
- WIDTH=64/DEPTH=1 IF/ID-equivalent: behaves as single stage register; pushes 0x0000_0004_2002_0001 -> visible next cycle; flush -> 0 (NOP) next cycle.
